// File: rtl/wb_regfile.sv
// Writeback stage: selects load/ALU data, commits it to a 2**ADDR_WIDTH-entry register file, and counts commits.
// Optional macro REGFILE_BYPASS_EN forwards the committing value to the read ports in the same cycle.
module wb_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wb_mem_data,
  input  logic [DATA_WIDTH-1:0] wb_alu_result,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic                  wb_reg_write,
  input  logic                  wb_mem_reg,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_commit,
  output logic [31:0]           wb_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [31:0]           commit_count;

  always_comb begin
    wb_data   = wb_mem_reg ? wb_mem_data : wb_alu_result;
    wb_commit = wb_reg_write && (wb_waddr != '0) && !rst;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      commit_count <= '0;
    end else if (wb_commit) begin
      regs[wb_waddr] <= wb_data;
      commit_count   <= commit_count + 32'd1;
    end
  end

  assign wb_count = commit_count;

  // wb_commit already excludes r0 and reset, so the bypass never touches r0.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_addr != '0) rs_data = regs[rs_addr];
    if (rt_addr != '0) rt_data = regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
    if (wb_commit && (rs_addr == wb_waddr)) rs_data = wb_data;
    if (wb_commit && (rt_addr == wb_waddr)) rt_data = wb_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, a monitor compares them against the DUT outputs.
module tb_wb_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  localparam int S_RS     = 0;
  localparam int S_RT     = 1;
  localparam int S_WBDATA = 2;
  localparam int S_COMMIT = 3;
  localparam int S_COUNT  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wb_mem_data;
  logic [DW-1:0] wb_alu_result;
  logic [AW-1:0] wb_waddr;
  logic          wb_reg_write;
  logic          wb_mem_reg;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] wb_data;
  logic          wb_commit;
  logic [31:0]   wb_count;

  wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .wb_mem_data(wb_mem_data), .wb_alu_result(wb_alu_result),
    .wb_waddr(wb_waddr), .wb_reg_write(wb_reg_write), .wb_mem_reg(wb_mem_reg),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_commit(wb_commit), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  event chk;
  int   checks = 0;
  int   errors = 0;

  // Monitor: drains every queued expectation against the outputs the DUT presents now.
  always @(chk) begin
    while (q.size() > 0) begin
      exp_t        it;
      logic [31:0] act;
      it = q.pop_front();
      case (it.sig)
        S_RS:     act = rs_data;
        S_RT:     act = rt_data;
        S_WBDATA: act = wb_data;
        S_COMMIT: act = {31'd0, wb_commit};
        default:  act = wb_count;
      endcase
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  task automatic expect_val(input string name, input int sig, input logic [31:0] e);
    exp_t it;
    it.name = name;
    it.sig  = sig;
    it.exp  = e;
    q.push_back(it);
  endtask

  task automatic sample();
    -> chk;
    #1;
  endtask

  task automatic drive(input logic we, input logic mr, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [AW-1:0] wa);
    wb_reg_write  = we;
    wb_mem_reg    = mr;
    wb_mem_data   = mem;
    wb_alu_result = alu;
    wb_waddr      = wa;
  endtask

  // Advance to the next falling edge; the rising edge in between is the commit edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rs_addr = '0;
    rt_addr = '0;
    drive(1'b1, 1'b0, 32'h0, 32'hAAAA_AAAA, 5'd5);
    #2;
    rs_addr = 5'd5;
    #1;
    expect_val("reset_rs", S_RS, 32'h0);
    expect_val("reset_count", S_COUNT, 32'h0);
    expect_val("reset_commit", S_COMMIT, 32'h0);
    sample();

    // Preload r5, then reset mid-program between edges.
    next_cycle();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 32'h6666_6666, 5'd6);
    #1;
    expect_val("preload_r5", S_RS, 32'h0000_1234);
    expect_val("preload_count", S_COUNT, 32'd1);
    sample();
    #1;
    rst = 1'b1;
    #1;
    expect_val("async_clear_rs", S_RS, 32'h0);
    expect_val("async_clear_count", S_COUNT, 32'h0);
    expect_val("rst_blocks_commit", S_COMMIT, 32'h0);
    sample();
    next_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rs_addr = 5'd6;
    #1;
    expect_val("inflight_discarded", S_RS, 32'h0);
    expect_val("post_rst_count", S_COUNT, 32'h0);
    sample();

    // ALU writeback to r7.
    drive(1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd7);
    rs_addr = 5'd1;
    #1;
    expect_val("alu_commit", S_COMMIT, 32'd1);
    expect_val("alu_wbdata", S_WBDATA, 32'hDEAD_BEEF);
    sample();
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rs_addr = 5'd7;
    #1;
    expect_val("alu_r7", S_RS, 32'hDEAD_BEEF);
    expect_val("alu_count", S_COUNT, 32'd1);
    sample();

    // Load writeback to r0 is dropped, r0 never bypassed.
    drive(1'b1, 1'b1, 32'hCAFE_F00D, 32'h2222_2222, 5'd0);
    rs_addr = 5'd0;
    #1;
    expect_val("r0_commit", S_COMMIT, 32'd0);
    expect_val("load_wbdata", S_WBDATA, 32'hCAFE_F00D);
    expect_val("r0_no_bypass", S_RS, 32'h0);
    sample();
    next_cycle();
    #1;
    expect_val("r0_stays_zero", S_RS, 32'h0);
    expect_val("r0_count", S_COUNT, 32'd1);
    sample();
    drive(1'b1, 1'b1, 32'hCAFE_F00D, 32'h2222_2222, 5'd3);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rs_addr = 5'd7;
    rt_addr = 5'd3;
    #1;
    expect_val("load_r3", S_RT, 32'hCAFE_F00D);
    expect_val("dual_read_r7", S_RS, 32'hDEAD_BEEF);
    expect_val("load_count", S_COUNT, 32'd2);
    sample();

    // Same-cycle read of the write target.
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0011, 5'd9);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0022, 5'd9);
    rs_addr = 5'd9;
    rt_addr = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    expect_val("rs_same_cycle", S_RS, 32'h0000_0022);
    expect_val("rt_same_cycle", S_RT, 32'h0000_0022);
`else
    expect_val("rs_same_cycle", S_RS, 32'h0000_0011);
    expect_val("rt_same_cycle", S_RT, 32'h0000_0011);
`endif
    sample();
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0099, 5'd9);
    #1;
    expect_val("rs_post_edge", S_RS, 32'h0000_0022);
    expect_val("rt_post_edge", S_RT, 32'h0000_0022);
    expect_val("no_bypass_when_we_low", S_RS, 32'h0000_0022);
    expect_val("r9_count", S_COUNT, 32'd4);
    sample();

    // Write enable low for three cycles.
    drive(1'b0, 1'b0, 32'h0, 32'h0000_0055, 5'd4);
    rs_addr = 5'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_val("we_low_wbdata", S_WBDATA, 32'h0000_0055);
      expect_val("we_low_commit", S_COMMIT, 32'd0);
      sample();
      next_cycle();
    end
    #1;
    expect_val("we_low_r4", S_RS, 32'h0);
    expect_val("we_low_count", S_COUNT, 32'd4);
    sample();

    // Counter wrap via deposit.
    dut.commit_count = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 32'h0, 32'h0000_ABCD, 5'd10);
    rs_addr = 5'd10;
    #1;
    expect_val("deposit_count", S_COUNT, 32'hFFFF_FFFF);
    sample();
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    expect_val("wrap_count", S_COUNT, 32'h0);
    expect_val("wrap_r10", S_RS, 32'h0000_ABCD);
    sample();

    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
